// File: rtl/aes_ctrl_pkg.sv
// aes_ctrl_pkg: shared state encodings, key-length codes and round counts for the AES round sequencer.
package aes_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_DONE} state_t;
    typedef enum logic [1:0] {KL_128 = 2'b00, KL_192 = 2'b01, KL_256 = 2'b10, KL_RSV = 2'b11} key_len_t;
    localparam int RND_W = 4;
    localparam logic [RND_W-1:0] NR_128 = 4'd10;
    localparam logic [RND_W-1:0] NR_192 = 4'd12;
    localparam logic [RND_W-1:0] NR_256 = 4'd14;
    function automatic logic [RND_W-1:0] nr_of(input logic [1:0] kl);
        return kl == KL_192 ? NR_192 : kl == KL_256 ? NR_256 : NR_128;
    endfunction
endpackage

// File: rtl/aes_rnd_cnt.sv
// aes_rnd_cnt: round and intra-round cycle counters with key-schedule stall, commit and last-round detect.
module aes_rnd_cnt
    import aes_ctrl_pkg::*;
#(
    parameter int RND_CYC = 1,
    parameter int CYC_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_start,
    input  logic             i_run,
    input  logic             i_key_rdy,
    input  logic [RND_W-1:0] i_nr,
    output logic [RND_W-1:0] o_rnd_cnt,
    output logic             o_commit,
    output logic             o_last
);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(RND_CYC - 1);
    logic [CYC_W-1:0] r_cyc;
    logic [RND_W-1:0] r_rnd;
    logic             w_at_end;
    assign w_at_end  = r_cyc == CYC_LAST;
    assign o_commit  = i_run && w_at_end && i_key_rdy;
    assign o_last    = r_rnd == i_nr;
    assign o_rnd_cnt = r_rnd;
    // a missing round key freezes both counters, so the round simply stretches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc <= '0;
            r_rnd <= '0;
        end else if (i_clr) begin
            r_cyc <= '0;
            r_rnd <= '0;
        end else if (i_start) begin
            r_cyc <= '0;
            r_rnd <= RND_W'(1);
        end else if (i_run && i_key_rdy) begin
            if (!w_at_end) begin
                r_cyc <= r_cyc + 1'b1;
            end else if (!o_last) begin
                r_cyc <= '0;
                r_rnd <= r_rnd + 1'b1;
            end
        end
    end
endmodule

// File: rtl/aes_round_ctrl.sv
// aes_round_ctrl: AES round sequencer; handshake in, LOAD plus Nr rounds, result held until downstream accepts.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int RND_CYC = 1,
    parameter int CYC_W   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic [1:0] i_key_len,
    input  logic       i_key_rdy,
    input  logic       i_abort,
    input  logic       i_ready,
    output logic       o_valid,
    output logic       o_ld,
    output logic       o_rnd_en,
    output logic [3:0] o_rnd_idx,
    output logic       o_last_rnd,
    output logic       o_busy,
    output logic       o_err
);
    state_t           r_state, w_next;
    logic [RND_W-1:0] r_nr, w_rnd;
    logic             r_err, w_acc, w_rsv, w_commit, w_last;
    assign w_rsv   = i_key_len == KL_RSV;
    assign o_ready = r_state == ST_IDLE || (r_state == ST_DONE && i_ready);
    assign w_acc   = i_valid && o_ready && !i_abort;
    aes_rnd_cnt #(.RND_CYC(RND_CYC), .CYC_W(CYC_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (i_abort || r_state == ST_IDLE),
        .i_start  (r_state == ST_LOAD),
        .i_run    (r_state == ST_ROUND),
        .i_key_rdy(i_key_rdy),
        .i_nr     (r_nr),
        .o_rnd_cnt(w_rnd),
        .o_commit (w_commit),
        .o_last   (w_last)
    );
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  w_next = (w_acc && !w_rsv) ? ST_LOAD : ST_IDLE;
            ST_LOAD:  w_next = ST_ROUND;
            ST_ROUND: w_next = (w_commit && w_last) ? ST_DONE : ST_ROUND;
            ST_DONE:  w_next = !i_ready ? ST_DONE : (w_acc && !w_rsv) ? ST_LOAD : ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
        if (i_abort) w_next = ST_IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_nr    <= NR_128;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_acc && w_rsv;
            if (w_acc && !w_rsv) r_nr <= nr_of(i_key_len);
        end
    end
    assign o_valid    = r_state == ST_DONE;
    assign o_ld       = r_state == ST_LOAD;
    assign o_busy     = r_state == ST_LOAD || r_state == ST_ROUND;
    assign o_rnd_en   = r_state == ST_ROUND && w_commit;
    assign o_rnd_idx  = r_state == ST_ROUND ? w_rnd : 4'd0;
    assign o_last_rnd = r_state == ST_ROUND && w_last;
    assign o_err      = r_err;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// tb_aes_round_ctrl: two sequencers (1 and 4 cycles per round) on shared stimulus, checked against a work-count model.
module tb_aes_round_ctrl;
    localparam int M_IDLE = 0, M_LOAD = 1, M_WORK = 2, M_DONE = 3;
    logic clk = 1'b0, rst = 1'b1;
    logic i_valid = 1'b0, i_key_rdy = 1'b0, i_abort = 1'b0, i_ready = 1'b0;
    logic [1:0] i_key_len = 2'd0;
    logic o_ready[2], o_valid[2], o_ld[2], o_rnd_en[2], o_last_rnd[2], o_busy[2], o_err[2];
    logic [3:0] o_rnd_idx[2];
    int n_vec = 0, n_err = 0;
    int rc[2] = '{1, 4};
    int m_mode[2], m_nr[2], m_work[2];
    bit m_err[2];
    always #5 clk = ~clk;
    aes_round_ctrl #(.RND_CYC(1), .CYC_W(3)) u_dut1 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready[0]), .i_key_len(i_key_len),
        .i_key_rdy(i_key_rdy), .i_abort(i_abort), .i_ready(i_ready), .o_valid(o_valid[0]),
        .o_ld(o_ld[0]), .o_rnd_en(o_rnd_en[0]), .o_rnd_idx(o_rnd_idx[0]),
        .o_last_rnd(o_last_rnd[0]), .o_busy(o_busy[0]), .o_err(o_err[0])
    );
    aes_round_ctrl #(.RND_CYC(4), .CYC_W(3)) u_dut4 (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready[1]), .i_key_len(i_key_len),
        .i_key_rdy(i_key_rdy), .i_abort(i_abort), .i_ready(i_ready), .o_valid(o_valid[1]),
        .o_ld(o_ld[1]), .o_rnd_en(o_rnd_en[1]), .o_rnd_idx(o_rnd_idx[1]),
        .o_last_rnd(o_last_rnd[1]), .o_busy(o_busy[1]), .o_err(o_err[1])
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask
    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = M_IDLE;
            m_nr[d] = 10;
            m_work[d] = 0;
            m_err[d] = 1'b0;
        end
    endtask
    // Each round needs rc key-ready cycles of work; round index and commit follow from the work done.
    task automatic step(input bit v, input bit [1:0] kl, input bit kr, input bit ab, input bit rdy);
        @(negedge clk);
        i_valid = v;
        i_key_len = kl;
        i_key_rdy = kr;
        i_abort = ab;
        i_ready = rdy;
        #1;
        for (int d = 0; d < 2; d++) begin
            int t, idx, cyc;
            bit rd, acc, wk;
            t = m_nr[d] * rc[d];
            idx = m_work[d] / rc[d] + 1;
            cyc = m_work[d] % rc[d];
            wk = m_mode[d] == M_WORK;
            rd = m_mode[d] == M_IDLE || (m_mode[d] == M_DONE && rdy);
            chk($sformatf("d%0d ready", d), o_ready[d], rd);
            chk($sformatf("d%0d valid", d), o_valid[d], m_mode[d] == M_DONE);
            chk($sformatf("d%0d ld", d), o_ld[d], m_mode[d] == M_LOAD);
            chk($sformatf("d%0d busy", d), o_busy[d], m_mode[d] == M_LOAD || wk);
            chk($sformatf("d%0d rnd_en", d), o_rnd_en[d], wk && kr && cyc == rc[d] - 1);
            chk($sformatf("d%0d rnd_idx", d), o_rnd_idx[d], wk ? idx : 0);
            chk($sformatf("d%0d last_rnd", d), o_last_rnd[d], wk && idx == m_nr[d]);
            chk($sformatf("d%0d err", d), o_err[d], m_err[d]);
            acc = v && rd && !ab;
            m_err[d] = acc && kl == 2'd3;
            if (ab) begin
                m_mode[d] = M_IDLE;
                m_work[d] = 0;
            end else begin
                case (m_mode[d])
                    M_IDLE: if (acc && kl != 2'd3) begin m_mode[d] = M_LOAD; m_nr[d] = 10 + 2 * kl; end
                    M_LOAD: begin m_mode[d] = M_WORK; m_work[d] = 0; end
                    M_WORK: if (kr) begin m_work[d]++; if (m_work[d] == t) m_mode[d] = M_DONE; end
                    default: if (rdy) begin
                        if (acc && kl != 2'd3) begin m_mode[d] = M_LOAD; m_nr[d] = 10 + 2 * kl; end
                        else m_mode[d] = M_IDLE;
                    end
                endcase
            end
        end
    endtask
    // Accept one block, measure accept-to-valid latency, then back-to-back accept and abort at round 3.
    task automatic lat_run(input bit [1:0] kl, input int stall_at, input int stall_len);
        int lat[2];
        lat = '{0, 0};
        step(0, 0, 1, 1, 0);
        step(1, kl, 1, 0, 0);
        for (int c = 1; c <= 80 && (lat[0] == 0 || lat[1] == 0); c++) begin
            step(0, 2'($urandom), !(c >= stall_at && c < stall_at + stall_len), 0, 0);
            for (int d = 0; d < 2; d++) if (lat[d] == 0 && o_valid[d]) lat[d] = c;
        end
        for (int d = 0; d < 2; d++)
            chk($sformatf("d%0d latency kl=%0d", d, kl), lat[d], 2 + (10 + 2 * kl) * rc[d] + stall_len);
        repeat (5) step(0, 0, 1, 0, 0);
        step(1, 2'd0, 1, 0, 1);
        step(0, 0, 1, 0, 0);
        chk("b2b ld", o_ld[0], 1);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        chk("abort rnd_idx", o_rnd_idx[0], 3);
        step(0, 0, 1, 0, 0);
        chk("abort busy", o_busy[0], 0);
        chk("abort ready", o_ready[0], 1);
    endtask
    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst ready", o_ready[0], 1);
        chk("rst busy", o_busy[1], 0);
        chk("rst idx", o_rnd_idx[0], 0);
        rst = 1'b0;
        lat_run(2'd0, 1000, 0);
        lat_run(2'd2, 1000, 0);
        lat_run(2'd1, 1000, 0);
        lat_run(2'd0, 6, 3);
        step(1, 2'd0, 1, 0, 0);
        repeat (60) step(0, 0, 1, 0, 0);
        chk("done valid", o_valid[1], 1);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        chk("abort done valid", o_valid[1], 0);
        step(1, 2'd3, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("rsv err", o_err[0], 1);
        step(0, 0, 1, 0, 0);
        chk("rsv err pulse", o_err[0], 0);
        chk("rsv no ld", o_ld[0], 0);
        step(1, 2'd0, 1, 0, 0);
        repeat (5) step(0, 0, 1, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", o_busy[0], 0);
        chk("async rst ready", o_ready[1], 1);
        chk("async rst idx", o_rnd_idx[0], 0);
        model_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (3000)
            step($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom_range(0, 9) != 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 2) != 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/aes_round_ctrl.md
Name: aes_round_ctrl

Overview:
Parametrised AES round sequencer that replaces the fixed single-shot control FSM.
- Accepts a block via a valid/ready handshake and latches the key length (128/192/256, i.e. Nr = 10/12/14).
- Drives the datapath through the initial load plus Nr rounds, with configurable cycles per round and a key-schedule stall input.
- Holds the result until downstream accepts it, supports abort, and allows back-to-back blocks.
- Sits between the AES top-level handshake and the round datapath / key-expansion units.

Parameters:
RND_CYC, 1, datapath cycles per round (legal 1..8)
CYC_W, 3, width of the intra-round cycle counter (must hold RND_CYC-1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
i_valid  in  1  upstream block available
o_ready  out  1  block accepted when i_valid && o_ready
i_key_len  in  2  00=AES-128, 01=AES-192, 10=AES-256, 11=reserved; sampled at accept
i_key_rdy  in  1  key schedule has the current round key available
i_abort  in  1  synchronous abort, highest priority
i_ready  in  1  downstream accepts result
o_valid  out  1  result in datapath valid
o_ld  out  1  load plaintext and apply the initial AddRoundKey
o_rnd_en  out  1  datapath commits one round this cycle
o_rnd_idx  out  4  current round number, 1..Nr; 0 outside ROUND
o_last_rnd  out  1  current round is Nr (skip MixColumns)
o_busy  out  1  high in LOAD and ROUND
o_err  out  1  one-cycle pulse, reserved key length accepted

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset: state=IDLE, rnd_cnt=0, cyc_cnt=0, nr_q=10.
  - Outputs while in IDLE: o_ready=1; o_valid, o_ld, o_rnd_en, o_last_rnd, o_busy, o_err=0; o_rnd_idx=0.
  - Upstream must not assert i_valid while rst is high.
- Outputs are a Moore decode of state and counters. The exception is o_ready = (IDLE) | (DONE & i_ready), a combinational path from i_ready.
- States:
  - IDLE: on accept with valid i_key_len, latch nr_q and go to LOAD. On accept with i_key_len=11, pulse o_err next cycle and stay IDLE.
  - LOAD: one cycle, o_ld=1, o_busy=1. Next state ROUND with rnd_cnt=1, cyc_cnt=0.
  - ROUND: o_busy=1, o_rnd_idx=rnd_cnt, o_last_rnd=(rnd_cnt==nr_q).
    - cyc_cnt increments each cycle until it reaches RND_CYC-1, then holds there.
    - o_rnd_en=1 only when cyc_cnt==RND_CYC-1 and i_key_rdy=1. With i_key_rdy low, the block stalls with no round commit and both counters held.
    - On commit: if rnd_cnt==nr_q go to DONE; else rnd_cnt+1 and cyc_cnt=0.
  - DONE: o_valid=1, held until i_ready.
    - i_ready with no accept: go to IDLE.
    - i_ready with i_valid: accept the next block (key length resampled) and go directly to LOAD.
    - i_ready with i_valid and reserved key length: go to IDLE with an o_err pulse.
- Latency with i_key_rdy always high: o_valid rises 2 + Nr*RND_CYC cycles after the accept edge. Example: AES-128, RND_CYC=1 gives 12.
- Throughput: one block per 2 + Nr*RND_CYC cycles when downstream is always ready.
- i_abort: from any state, next state is IDLE with all counters cleared. This drops o_valid even in DONE. An accept in the same cycle as i_abort is ignored.
- i_key_len changes after accept have no effect on the block in flight.
- Illegal state encodings recover to IDLE.

Decomposition:
- Package aes_ctrl_pkg holds:
  - state encodings (IDLE, LOAD, ROUND, DONE);
  - key-length codes;
  - NR_128=10, NR_192=12, NR_256=14;
  - round counter width 4.
- Sub-module aes_rnd_cnt holds the round and cycle counters (cyc_cnt, rnd_cnt, commit and last-round detection, stall hold, clear). The FSM stays in aes_round_ctrl.

Test Plan:
- AES-128, RND_CYC=1, i_key_rdy=1, i_ready=1: one accept gives o_ld for 1 cycle, o_rnd_en for 10 cycles with o_rnd_idx 1..10, o_last_rnd only at idx 10, o_valid at cycle 12.
- AES-256, RND_CYC=4: 14 o_rnd_en pulses spaced 4 cycles apart, o_valid at cycle 58. AES-192 with RND_CYC=1 gives o_valid at 14.
- Drop i_key_rdy for 3 cycles at round 5 (AES-128, RND_CYC=1): no o_rnd_en during the stall, o_rnd_idx holds at 5, o_valid is delayed to cycle 15.
- Hold i_ready=0 for 5 cycles in DONE: o_valid stays high and o_ready=0. Then i_ready=1 with i_valid=1: second block goes straight to LOAD with no IDLE cycle.
- Assert i_abort in ROUND at round 3 and separately in DONE: IDLE next cycle, o_valid/o_busy=0, o_ready=1. Assert rst mid-ROUND: immediate asynchronous return to IDLE outputs.
- Accept with i_key_len=11: o_err is a single-cycle pulse, o_ld never asserted, state remains IDLE.
